// File: rtl/fpcif_arb_pkg.sv
// Shared definitions for the fpcif conversion-unit arbiter family.
//   state_t      : sequencer states (IDLE -> ISSUE -> DONE)
//   FLG_*        : bit positions inside the 5-bit {v,i,o,u,x} flag vector
//   RND_*        : rounding mode codes carried on the rnd inputs
package fpcif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int FLG_W = 5;
    localparam int FLG_V = 4;
    localparam int FLG_I = 3;
    localparam int FLG_O = 2;
    localparam int FLG_U = 1;
    localparam int FLG_X = 0;

    localparam logic [1:0] RND_NEAR = 2'b00;
    localparam logic [1:0] RND_ZERO = 2'b01;
    localparam logic [1:0] RND_DOWN = 2'b10;
    localparam logic [1:0] RND_UP   = 2'b11;

endpackage

// File: rtl/fpcif_arb_if.sv
// Interface to one int-to-float conversion unit.
//   run   : operand/rounding mode valid, unit should work on them
//   stall : unit not finished; z/flags not yet valid
//   rnd   : rounding mode, x : signed integer operand
//   z     : single-precision result, flags : {v,i,o,u,x}
// master = the side that issues operations (arbiter), slave = the unit.
interface fpcif_arb_if;
    import fpcif_pkg::*;

    logic             run;
    logic             stall;
    logic [1:0]       rnd;
    logic [31:0]      x;
    logic [31:0]      z;
    logic [FLG_W-1:0] flags;

    modport master (output run, rnd, x, input stall, z, flags);
    modport slave  (input run, rnd, x, output stall, z, flags);

endinterface

// File: rtl/fpcif_arb_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector
//   last : index of the most recently served requester
//   any  : at least one request present
//   win  : first requester at or after (last+1) mod NREQ, wrapping
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            any,
    output logic [IW-1:0]   win
);

    // Each requester's distance from the search start; the smallest
    // distance among active requests wins. Avoids variable bit-selects.
    always_comb begin
        int best_d;
        int d;
        any    = 1'b0;
        win    = '0;
        best_d = NREQ;
        d      = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - int'(last) - 1 + 2 * NREQ) % NREQ;
            if (req[i] && (d < best_d)) begin
                any    = 1'b1;
                win    = IW'(i);
                best_d = d;
            end
        end
    end

endmodule

// File: rtl/fpcif_arb.sv
// Shares one int-to-float conversion unit between NREQ requesters.
//   clk, rst_n       : clock, synchronous active-low reset
//   req/rnd/x        : per-requester request, rounding mode, operand
//   ack              : one-cycle pulse, operand of that requester latched
//   done             : one-cycle pulse, z/flags valid for that requester
//   z, flags         : last captured result and its flags
//   acc_flags        : sticky OR of captured flags, cleared by acc_clr
//   fu               : master port to the conversion unit
module fpcif_arb
    import fpcif_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] rnd,
    input  logic [32*NREQ-1:0] x,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [31:0]       z,
    output logic [FLG_W-1:0]  flags,
    output logic [FLG_W-1:0]  acc_flags,
    input  logic              acc_clr,
    fpcif_arb_if.master       fu
);

    state_t             state_reg;
    logic [IW-1:0]      last_reg;
    logic [IW-1:0]      g_reg;
    logic [31:0]        op_x_reg;
    logic [1:0]         op_rnd_reg;
    logic [NREQ-1:0]    ack_reg;
    logic [NREQ-1:0]    done_reg;
    logic [31:0]        z_reg;
    logic [FLG_W-1:0]   flags_reg;
    logic [FLG_W-1:0]   acc_reg;

    logic               any;
    logic [IW-1:0]      win;
    logic [NREQ-1:0]    win_oh;
    logic [NREQ-1:0]    g_oh;
    logic [31:0]        sel_x;
    logic [1:0]         sel_rnd;
    logic               capture;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req  (req),
        .last (last_reg),
        .any  (any),
        .win  (win)
    );

    // One-hot decodes of the winner and of the granted index drive the
    // ack/done pulses and the operand mux without indexed writes.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_oh_dec
            assign win_oh[gi] = (win == IW'(gi));
            assign g_oh[gi]   = (g_reg == IW'(gi));
        end
    endgenerate

    always_comb begin
        sel_x   = '0;
        sel_rnd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                sel_x   = x[i*32 +: 32];
                sel_rnd = rnd[i*2 +: 2];
            end
        end
    end

    assign capture = (state_reg == ST_ISSUE) && !fu.stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            last_reg   <= IW'(NREQ - 1);
            g_reg      <= '0;
            op_x_reg   <= '0;
            op_rnd_reg <= '0;
            ack_reg    <= '0;
            done_reg   <= '0;
            z_reg      <= '0;
            flags_reg  <= '0;
            acc_reg    <= '0;
        end else begin
            ack_reg  <= '0;
            done_reg <= '0;
            // A clear in the capture cycle must not drop the new flags.
            acc_reg  <= (acc_clr ? '0 : acc_reg) | (capture ? fu.flags : '0);
            case (state_reg)
                ST_IDLE: begin
                    if (any) begin
                        op_x_reg   <= sel_x;
                        op_rnd_reg <= sel_rnd;
                        g_reg      <= win;
                        ack_reg    <= win_oh;
                        state_reg  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!fu.stall) begin
                        z_reg     <= fu.z;
                        flags_reg <= fu.flags;
                        done_reg  <= g_oh;
                        last_reg  <= g_reg;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE:  state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ack       = ack_reg;
    assign done      = done_reg;
    assign z         = z_reg;
    assign flags     = flags_reg;
    assign acc_flags = acc_reg;
    assign fu.run    = (state_reg == ST_ISSUE);
    assign fu.x      = op_x_reg;
    assign fu.rnd    = op_rnd_reg;

endmodule

// File: tb/tb_fpcif_arb.sv
module tb_fpcif_arb;

    localparam int NREQ = 3;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] rnd;
    logic [32*NREQ-1:0] x;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   done;
    logic [31:0]       z;
    logic [4:0]        flags;
    logic [4:0]        acc_flags;
    logic              acc_clr;
    logic              stall_drv;
    logic [36:0]       fu_resp;

    int n_tests = 0;
    int n_fail  = 0;

    fpcif_arb_if fu_if ();

    fpcif_arb #(.NREQ(NREQ), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rnd       (rnd),
        .x         (x),
        .ack       (ack),
        .done      (done),
        .z         (z),
        .flags     (flags),
        .acc_flags (acc_flags),
        .acc_clr   (acc_clr),
        .fu        (fu_if)
    );

    always #5 clk = ~clk;

    // Behavioural int32 -> float32 conversion: returns {flags[4:0], z[31:0]}.
    function automatic logic [36:0] i2f(input logic [31:0] xi, input logic [1:0] rm);
        logic        s;
        logic [31:0] mag, mant, rem, half;
        logic        inex, up;
        int          p, sh;
        s = xi[31];
        mag = s ? (~xi + 32'd1) : xi;
        if (mag == 32'd0) return '0;
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        inex = 1'b0;
        if (p <= 23) begin
            mant = mag << (23 - p);
        end else begin
            sh   = p - 23;
            mant = mag >> sh;
            rem  = mag & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            inex = (rem != 32'd0);
            case (rm)
                2'b00:   up = (rem > half) || ((rem == half) && mant[0]);
                2'b01:   up = 1'b0;
                2'b10:   up = inex && s;
                default: up = inex && !s;
            endcase
            if (up) mant = mant + 32'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                p = p + 1;
            end
        end
        return {4'b0000, inex, s, 8'(p + 127), mant[22:0]};
    endfunction

    // Conversion unit model: answers combinationally, stall under bench control.
    always_comb fu_resp = i2f(fu_if.x, fu_if.rnd);
    assign fu_if.z     = fu_resp[31:0];
    assign fu_if.flags = fu_resp[36:32];
    assign fu_if.stall = stall_drv;

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration state: index served last, pending requests.
    int          model_last;
    logic [4:0]  acc_m;
    logic        pend [NREQ];
    logic [31:0] px   [NREQ];
    logic [1:0]  prm  [NREQ];

    function automatic int model_winner();
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
        end
        return -1;
    endfunction

    // One complete operation on requester r from IDLE back to IDLE.
    task automatic run_op(input int r, input logic [31:0] xv, input logic [1:0] rm,
                          input int stall_n, input logic clr_cap,
                          output logic [31:0] zo, output logic [4:0] fo);
        req[r] = 1'b1;
        x[r*32 +: 32] = xv;
        rnd[r*2 +: 2] = rm;
        @(negedge clk);
        chk("op_ack", 64'(ack), 64'(onehot(r)));
        chk("op_ack_nodone", 64'(done), 64'd0);
        req[r] = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
            stall_drv = 1'b1;
            chk("stall_run", 64'(fu_if.run), 64'd1);
            chk("stall_fu_x", 64'(fu_if.x), 64'(xv));
            @(negedge clk);
            chk("stall_ack", 64'(ack), 64'd0);
            chk("stall_done", 64'(done), 64'd0);
        end
        stall_drv = 1'b0;
        acc_clr   = clr_cap;
        chk("op_run", 64'(fu_if.run), 64'd1);
        chk("op_fu_x", 64'(fu_if.x), 64'(xv));
        @(negedge clk);
        acc_clr = 1'b0;
        chk("op_done", 64'(done), 64'(onehot(r)));
        zo = z;
        fo = flags;
        model_last = r;
        @(negedge clk);
        chk("op_idle_done", 64'(done), 64'd0);
    endtask

    typedef struct {
        int          r;
        logic [31:0] xv;
        logic [1:0]  rm;
        logic [31:0] ez;
        logic [4:0]  ef;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] zo;
        logic [4:0]  fo;
        logic [36:0] e;
        int          w, k, n_done;
        logic        clr, anyp;

        vecs[0] = '{0, 32'h00000001, 2'b00, 32'h3F800000, 5'h00};
        vecs[1] = '{1, 32'h80000000, 2'b00, 32'hCF000000, 5'h00};
        vecs[2] = '{2, 32'h7FFFFFFF, 2'b00, 32'h4F000000, 5'h01};
        vecs[3] = '{0, 32'h7FFFFFFF, 2'b01, 32'h4EFFFFFF, 5'h01};
        vecs[4] = '{1, 32'h7FFFFFFF, 2'b10, 32'h4EFFFFFF, 5'h01};
        vecs[5] = '{2, 32'h7FFFFFFF, 2'b11, 32'h4F000000, 5'h01};
        vecs[6] = '{0, 32'h00000000, 2'b00, 32'h00000000, 5'h00};
        vecs[7] = '{1, 32'hFFFFFFFF, 2'b00, 32'hBF800000, 5'h00};
        vecs[8] = '{2, 32'h01000001, 2'b00, 32'h4B800000, 5'h01};

        rst_n = 1'b0; req = '0; rnd = '0; x = '0; acc_clr = 1'b0; stall_drv = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_z", 64'(z), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_acc", 64'(acc_flags), 64'd0);
        chk("rst_run", 64'(fu_if.run), 64'd0);
        chk("rst_fu_x", 64'(fu_if.x), 64'd0);
        chk("rst_fu_rnd", 64'(fu_if.rnd), 64'd0);
        rst_n = 1'b1;
        model_last = NREQ - 1;

        // Table-driven single-requester conversions.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].r, vecs[i].xv, vecs[i].rm, 0, 1'b0, zo, fo);
            chk("vec_z", 64'(zo), 64'(vecs[i].ez));
            chk("vec_flags", 64'(fo), 64'(vecs[i].ef));
            $display("[TB] vec %0d req%0d x=%h rnd=%0d z=%h flags=%h",
                     i, vecs[i].r, vecs[i].xv, vecs[i].rm, zo, fo);
        end

        // Two requesters held continuously: strict alternation starting at 0.
        x[0 +: 32]  = 32'd1000;
        x[32 +: 32] = 32'hFFFFF000;
        rnd = '0;
        req = 3'b011;
        for (int n = 0; n < 4; n++) begin
            w = n % 2;
            @(negedge clk);
            chk("rr_ack", 64'(ack), 64'(onehot(w)));
            @(negedge clk);
            chk("rr_done", 64'(done), 64'(onehot(w)));
            e = i2f(x[w*32 +: 32], 2'b00);
            chk("rr_z", 64'(z), 64'(e[31:0]));
            $display("[TB] rr grant %0d req%0d z=%h", n, w, z);
            @(negedge clk);
        end
        req = '0;
        model_last = 1;

        // Stall for three cycles after ack.
        run_op(0, 32'd12345, 2'b00, 3, 1'b0, zo, fo);
        chk("stall_z", 64'(zo), 64'(32'h4640E400));
        $display("[TB] stall op z=%h", zo);

        // Sticky flag sequence.
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("acc_clr0", 64'(acc_flags), 64'd0);
        run_op(1, 32'h7FFFFFFF, 2'b00, 0, 1'b0, zo, fo);
        chk("acc_inexact", 64'(acc_flags), 64'h01);
        run_op(2, 32'd1, 2'b00, 0, 1'b0, zo, fo);
        chk("acc_exact", 64'(acc_flags), 64'h01);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("acc_clr1", 64'(acc_flags), 64'd0);
        run_op(0, 32'h7FFFFFFF, 2'b00, 0, 1'b1, zo, fo);
        chk("acc_clr_cap", 64'(acc_flags), 64'h01);
        $display("[TB] acc sequence acc_flags=%h", acc_flags);

        // Randomized traffic against the reference model.
        acc_m = acc_flags;
        n_done = 0;
        for (int t = 0; t < 400; t++) begin
            anyp = 1'b0;
            if (t < 300) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
                        pend[i] = 1'b1;
                        px[i]   = ($urandom_range(1, 0) == 1) ? $urandom : 32'($urandom_range(300, 0));
                        prm[i]  = 2'($urandom_range(3, 0));
                    end
                end
                if (!pend[0] && !pend[1] && !pend[2]) begin
                    pend[0] = 1'b1; px[0] = $urandom; prm[0] = 2'($urandom_range(3, 0));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i]) anyp = 1'b1;
                req[i] = pend[i];
                if (pend[i]) begin
                    x[i*32 +: 32] = px[i];
                    rnd[i*2 +: 2] = prm[i];
                end
            end
            if (!anyp) break;
            w = model_winner();
            clr = ($urandom_range(3, 0) == 0);
            acc_clr = clr;
            @(negedge clk);
            if (clr) acc_m = '0;
            chk("rnd_ack", 64'(ack), 64'(onehot(w)));
            req[w] = 1'b0;
            pend[w] = 1'b0;
            k = $urandom_range(2, 0);
            for (int s = 0; s < k; s++) begin
                stall_drv = 1'b1;
                clr = ($urandom_range(3, 0) == 0);
                acc_clr = clr;
                @(negedge clk);
                if (clr) acc_m = '0;
                chk("rnd_stall_done", 64'(done), 64'd0);
            end
            stall_drv = 1'b0;
            clr = ($urandom_range(3, 0) == 0);
            acc_clr = clr;
            @(negedge clk);
            e = i2f(px[w], prm[w]);
            acc_m = (clr ? 5'd0 : acc_m) | e[36:32];
            chk("rnd_done", 64'(done), 64'(onehot(w)));
            chk("rnd_z", 64'(z), 64'(e[31:0]));
            chk("rnd_flags", 64'(flags), 64'(e[36:32]));
            chk("rnd_acc", 64'(acc_flags), 64'(acc_m));
            model_last = w;
            clr = ($urandom_range(3, 0) == 0);
            acc_clr = clr;
            @(negedge clk);
            if (clr) acc_m = '0;
            acc_clr = 1'b0;
            chk("rnd_acc_done", 64'(acc_flags), 64'(acc_m));
            n_done++;
            $display("[TB] txn %0d req%0d x=%h rnd=%0d stall=%0d z=%h flags=%h acc=%h",
                     t, w, px[w], prm[w], k, z, flags, acc_flags);
        end
        req = '0;

        // Reset during ISSUE: no done, all outputs cleared, requester 0 wins next.
        run_op(0, 32'd7, 2'b00, 0, 1'b0, zo, fo);
        req[1] = 1'b1;
        x[32 +: 32] = 32'h7FFFFFFF;
        @(negedge clk);
        chk("rstop_ack", 64'(ack), 64'(onehot(1)));
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        chk("rstop_done", 64'(done), 64'd0);
        chk("rstop_ack0", 64'(ack), 64'd0);
        chk("rstop_z", 64'(z), 64'd0);
        chk("rstop_flags", 64'(flags), 64'd0);
        chk("rstop_acc", 64'(acc_flags), 64'd0);
        chk("rstop_run", 64'(fu_if.run), 64'd0);
        chk("rstop_fu_x", 64'(fu_if.x), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstop_nodone", 64'(done), 64'd0);
        x[0 +: 32] = 32'd3;
        rnd = '0;
        req = 3'b011;
        @(negedge clk);
        chk("rstop_first", 64'(ack), 64'(onehot(0)));
        req = '0;
        @(negedge clk);
        chk("rstop_first_done", 64'(done), 64'(onehot(0)));
        chk("rstop_first_z", 64'(z), 64'(32'h40400000));
        $display("[TB] reset-in-issue sequence z=%h", z);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpcif_arb.md
Name: fpcif_arb

Overview:
- Arbiter and sequencer that shares one int-to-float conversion unit (the fpcif run/stall/rnd/x/z/flags interface) between NREQ requesters.
- Per request: captures operand and rounding mode, drives the unit until it stops stalling, registers result and flags, and returns them with a done pulse.
- Keeps an accrued (sticky) exception-flag register for the FPU status path.
- Sits between the issue logic of the integer/FP pipelines and the single conversion unit instance.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IW, 2, width of grant index; must be at least clog2(NREQ).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  request per requester; held with operand until ack.
- rnd  in  2*NREQ  rounding mode per requester (00 near, 01 zero, 10 down, 11 up).
- x  in  32*NREQ  signed integer operand per requester.
- ack  out  NREQ  one-cycle pulse: operand of that requester accepted.
- done  out  NREQ  one-cycle pulse: z/flags valid for that requester.
- z  out  32  result bus, shared by all requesters.
- flags  out  5  flags of last result {v,i,o,u,x}.
- acc_flags  out  5  OR of all result flags since reset or last clear.
- acc_clr  in  1  synchronous clear of acc_flags.
- fu_run  out  1  run to conversion unit.
- fu_stall  in  1  stall from conversion unit.
- fu_rnd  out  2  latched rounding mode to unit.
- fu_x  out  32  latched operand to unit.
- fu_z  in  32  unit result.
- fu_flags  in  5  unit flags.

Behaviour:
- Reset (rst_n low at an edge):
  - state=IDLE; ack=0, done=0, z=0, flags=0, acc_flags=0, fu_run=0, fu_x=0, fu_rnd=0.
  - last=NREQ-1, so requester 0 wins first.
  - Reset mid-operation abandons the operation; no done is issued.
- States: IDLE, ISSUE, DONE. Encoding is binary, 2 bits.
- IDLE:
  - If any req bit is set, winner g = first set bit searching from (last+1) mod NREQ upward, wrapping.
  - On the edge: latch x[g], rnd[g] into op regs; latch g; ack[g]<=1; state<=ISSUE.
  - With no request: stay in IDLE, outputs unchanged.
- ISSUE:
  - fu_run=1 (combinational from state); fu_x/fu_rnd come from op regs and stay stable.
  - If fu_stall=0 on the edge: z<=fu_z, flags<=fu_flags, done[g]<=1, last<=g, state<=DONE.
  - If fu_stall=1: remain in ISSUE; fu_run stays high.
- DONE: state<=IDLE on the next edge. req is not sampled in DONE.
- ack and done are registered and high for exactly one cycle.
- Latency with fu_stall=0:
  - req seen high in IDLE cycle n.
  - ack high in cycle n+1; done high in cycle n+2.
  - Next grant decision in cycle n+3, so peak throughput is one conversion per 3 cycles.
- Requester handshake:
  - May drop req in the ack cycle or any later cycle.
  - req still high in the next IDLE cycle counts as a new request.
- z/flags hold their value until the next capture.
- acc_flags on each edge: next = (acc_clr ? 0 : acc_flags) | (capture ? fu_flags : 0).
  - When clear and capture coincide, the new flags survive.
- Simultaneous requests: round-robin only. Requester g is never granted twice while another requester holds req continuously.
- req bits for requesters other than the winner are ignored outside IDLE.

Decomposition:
- Shared package fpcif_pkg:
  - State constants ST_IDLE, ST_ISSUE, ST_DONE.
  - Flag bit indices FLG_V=4, FLG_I=3, FLG_O=2, FLG_U=1, FLG_X=0.
  - Rounding codes RND_NEAR/ZERO/DOWN/UP.
- One sub-module: rr_pick (combinational).
  - Inputs: req vector, last index.
  - Outputs: any flag, winner index.
  - Reusable by later shared FP units.

Test Plan:
- Reset, then req[0]=1, x[0]=32'h00000001, rnd=00:
  - ack[0] in cycle 1, done[0] in cycle 2.
  - z=32'h3F800000, flags=5'h00.
- Single requester, x=32'h80000000, rnd=00 -> z=32'hCF000000, flags=0.
- Single requester, x=32'h7FFFFFFF:
  - rnd=00 -> z=32'h4F000000, flags=5'h01.
  - rnd=01 -> z=32'h4EFFFFFF, flags=5'h01.
- req[0] and req[1] held continuously with distinct x:
  - ack order 0,1,0,1.
  - Each done index matches the preceding ack; z matches that requester's operand.
- fu_stall forced high 3 cycles after ack:
  - fu_run high 4 consecutive cycles, fu_x constant.
  - done delayed by 3 cycles; no extra ack during the stall.
- acc_flags sequence:
  - Inexact op -> acc_flags=5'h01.
  - Exact op -> stays 5'h01.
  - acc_clr alone -> 5'h00.
  - acc_clr in the capture cycle of an inexact op -> 5'h01.
  - rst_n low during ISSUE -> no done pulse; all outputs 0 next cycle; requester 0 wins next.
